// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between NREQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_OPCHECK_EN to flag op codes above 3 via resp_err and force resp_q to 0.
module alu_arbiter #(
  parameter int OPERANDSIZE = 64,
  parameter int NREQ        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*OPERANDSIZE-1:0] req_a,
  input  logic [NREQ*OPERANDSIZE-1:0] req_b,
  input  logic [NREQ*12-1:0]          req_op,
  output logic [OPERANDSIZE-1:0]      alu_a,
  output logic [OPERANDSIZE-1:0]      alu_b,
  output logic [11:0]                 alu_op,
  input  logic [OPERANDSIZE-1:0]      alu_q,
  output logic                        resp_valid,
  output logic [$clog2(NREQ)-1:0]     resp_id,
  output logic [OPERANDSIZE-1:0]      resp_q,
  output logic                        resp_err,
  input  logic                        resp_ready
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state_d, state_q;
  logic [IDW-1:0]         ptr_d, ptr_q;
  logic [IDW-1:0]         resp_id_d, resp_id_q;
  logic [OPERANDSIZE-1:0] alu_a_d, alu_a_q;
  logic [OPERANDSIZE-1:0] alu_b_d, alu_b_q;
  logic [11:0]            alu_op_d, alu_op_q;
  logic [OPERANDSIZE-1:0] resp_q_d, resp_q_q;

  logic [OPERANDSIZE-1:0] a_arr  [NREQ];
  logic [OPERANDSIZE-1:0] b_arr  [NREQ];
  logic [11:0]            op_arr [NREQ];

  logic                   grant_found;
  logic [IDW-1:0]         grant_idx;
  logic [IDW-1:0]         cand_idx;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i]  = req_a[i*OPERANDSIZE +: OPERANDSIZE];
    assign b_arr[i]  = req_b[i*OPERANDSIZE +: OPERANDSIZE];
    assign op_arr[i] = req_op[i*12 +: 12];
  end

  // First valid requester at or after the pointer, wrapping at NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand_idx = IDW'((int'(ptr_q) + i) % NREQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

`ifdef ALU_ARBITER_OPCHECK_EN
  logic resp_err_d, resp_err_q;
  logic op_illegal;
  assign op_illegal = (alu_op_q > 12'd3);
  assign resp_err   = resp_err_q;
`else
  assign resp_err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    resp_id_d = resp_id_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    resp_q_d  = resp_q_q;
`ifdef ALU_ARBITER_OPCHECK_EN
    resp_err_d = resp_err_q;
`endif
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          alu_a_d   = a_arr[grant_idx];
          alu_b_d   = b_arr[grant_idx];
          alu_op_d  = op_arr[grant_idx];
          resp_id_d = grant_idx;
          ptr_d     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
`ifdef ALU_ARBITER_OPCHECK_EN
        resp_err_d = op_illegal;
        resp_q_d   = op_illegal ? '0 : alu_q;
`else
        resp_q_d   = alu_q;
`endif
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A grant strobe during reset would be lost, so suppress it.
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      resp_id_q <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      resp_q_q  <= '0;
`ifdef ALU_ARBITER_OPCHECK_EN
      resp_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      resp_id_q <= resp_id_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      resp_q_q  <= resp_q_d;
`ifdef ALU_ARBITER_OPCHECK_EN
      resp_err_q <= resp_err_d;
`endif
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign resp_id    = resp_id_q;
  assign resp_q     = resp_q_q;
  assign resp_valid = (state_q == RESP);

endmodule
